// File: rtl/imem_loader.sv
// Loads a big-endian byte stream (16-bit word count, then words) into instruction memory; holds the CPU in reset until finished.
// Latency: one memory write per 4 accepted bytes; start_i to done_o is at least 4 + 4*N cycles.
// Backpressure: in_ready_o is high only during the header and data phases, and bytes offered at other times are not consumed.
module imem_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  in_valid_i,
  input  logic [7:0]            in_data_i,
  output logic                  in_ready_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_data_o,
  output logic                  cpu_rst_n_o,
  output logic                  done_o,
  output logic                  len_err_o
);

  // Number of instruction words the memory holds. One spare bit keeps N = DEPTH representable.
  localparam logic [16:0]       DEPTH  = 17'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] WC_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    FLUSH,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            len_hi_q, len_hi_d;
  logic [15:0]           len_q, len_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [ADDR_WIDTH:0]   word_cnt_q, word_cnt_d;
  logic [23:0]           word_q, word_d;
  logic                  we_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [31:0]           data_d;
  logic                  cpu_rst_n_d;
  logic                  done_d;
  logic                  len_err_d;

  logic                  xfer;
  logic [15:0]           hdr_n;
  logic [ADDR_WIDTH:0]   wc_inc;

  // Ready is decoded from registered state only, so it never depends on in_valid_i.
  assign in_ready_o = (state_q == LEN_HI) || (state_q == LEN_LO) || (state_q == DATA);
  assign xfer       = in_valid_i && in_ready_o;
  assign hdr_n      = {len_hi_q, in_data_i};
  assign wc_inc     = word_cnt_q + WC_ONE;

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state plus next values of counters, word assembly and the registered outputs.
  always_comb begin
    state_d     = state_q;
    len_hi_d    = len_hi_q;
    len_d       = len_q;
    byte_cnt_d  = byte_cnt_q;
    word_cnt_d  = word_cnt_q;
    word_d      = word_q;
    we_d        = 1'b0;
    addr_d      = mem_addr_o;
    data_d      = mem_data_o;
    cpu_rst_n_d = cpu_rst_n_o;
    done_d      = done_o;
    len_err_d   = len_err_o;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = LEN_HI;
      end
      LEN_HI: begin
        if (xfer) begin
          len_hi_d = in_data_i;
          state_d  = LEN_LO;
        end
      end
      LEN_LO: begin
        if (xfer) begin
          len_d = hdr_n;
          if (hdr_n == 16'd0) begin
            state_d = DONE;
          end else if ({1'b0, hdr_n} > DEPTH) begin
            // Image cannot fit: flag it and write nothing.
            len_err_d = 1'b1;
            state_d   = DONE;
          end else begin
            byte_cnt_d = 2'd0;
            word_cnt_d = '0;
            state_d    = DATA;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          word_d     = {word_q[15:0], in_data_i};
          if (byte_cnt_q == 2'd3) begin
            we_d       = 1'b1;
            data_d     = {word_q, in_data_i};
            addr_d     = word_cnt_q[ADDR_WIDTH-1:0];
            word_cnt_d = wc_inc;
            if (17'(wc_inc) == {1'b0, len_q}) state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        // One cycle after the final write strobe, so the CPU cannot fetch a stale word.
        cpu_rst_n_d = 1'b1;
        done_d      = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (start_i) begin
          cpu_rst_n_d = 1'b0;
          done_d      = 1'b0;
          len_err_d   = 1'b0;
          state_d     = LEN_HI;
        end else begin
          done_d      = 1'b1;
          cpu_rst_n_d = !len_err_o;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output registers; reset abandons any partial load and holds the CPU in reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      len_hi_q    <= '0;
      len_q       <= '0;
      byte_cnt_q  <= '0;
      word_cnt_q  <= '0;
      word_q      <= '0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_data_o  <= '0;
      cpu_rst_n_o <= 1'b0;
      done_o      <= 1'b0;
      len_err_o   <= 1'b0;
    end else begin
      len_hi_q    <= len_hi_d;
      len_q       <= len_d;
      byte_cnt_q  <= byte_cnt_d;
      word_cnt_q  <= word_cnt_d;
      word_q      <= word_d;
      mem_we_o    <= we_d;
      mem_addr_o  <= addr_d;
      mem_data_o  <= data_d;
      cpu_rst_n_o <= cpu_rst_n_d;
      done_o      <= done_d;
      len_err_o   <= len_err_d;
    end
  end

endmodule
